mem_interface: RTL and testbench



---
 rtl/mem_interface.sv | 136 +++++++++++++
 tb/tb_mem_interface.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// MAR/MDR memory interface: loads from the datapath bus and sequences RAM read/write
// transactions with a ready handshake. Define MEM_TIMEOUT_EN to add the wait timeout and ERR path.
module mem_interface #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [31:0]           bus_in,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_out,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [31:0]           mdr_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] mar;
  logic [31:0]           mdr;
  logic                  timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_interface: TIMEOUT must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Ready on the same edge as the last allowed wait cycle takes precedence.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !mem_ready;

  // Only IDLE can enter READ/WRITE, so clearing while idle covers every entry.
  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if ((state == READ || state == WRITE) && !mem_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      err_q <= 1'b0;
    end else if (state == IDLE && (Read || Write)) begin
      err_q <= 1'b0;
    end else if (state == ERR) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Read) begin
          state_nxt = READ;
        end else if (Write) begin
          state_nxt = WRITE;
        end
      end
      READ, WRITE: begin
        if (mem_ready) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    mem_rd = (state == READ);
    mem_wr = (state == WRITE);
    done   = (state == DONE);
    busy   = (state != IDLE);
  end

  // Bus loads only while idle; read data is captured on the ready edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE && MARin) begin
        mar <= bus_in[ADDR_WIDTH-1:0];
      end
      if (state == IDLE && MDRin) begin
        mdr <= bus_in;
      end else if (state == READ && mem_ready) begin
        mdr <= mem_data_in;
      end
    end
  end

  assign mem_addr     = mar;
  assign mem_data_out = mdr;
  assign mdr_out      = mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: register loads, zero-wait and wait-state transfers,
// priority/ignore rules, timeout (when MEM_TIMEOUT_EN is defined) and mid-transaction clear.
module tb_mem_interface;

  localparam int ADDR_WIDTH = 9;
  localparam int TIMEOUT    = 15;

  logic                  clock = 1'b0;
  logic                  clear;
  logic [31:0]           bus_in;
  logic                  MARin, MDRin, Read, Write, mem_ready;
  logic [31:0]           mem_data_in;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data_out, mdr_out;
  logic                  mem_rd, mem_wr, busy, done, error;

  int n_checks = 0;
  int n_errors = 0;
  logic done_seen;

  mem_interface #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mem_ready(mem_ready), .mem_data_in(mem_data_in),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mdr_out(mdr_out), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd"},   {31'd0, mem_rd}, 32'd0);
    check({tag, "_wr"},   {31'd0, mem_wr}, 32'd0);
    check({tag, "_done"}, {31'd0, done},   32'd0);
    check({tag, "_busy"}, {31'd0, busy},   32'd0);
    check({tag, "_err"},  {31'd0, error},  32'd0);
    check({tag, "_addr"}, {23'd0, mem_addr}, 32'd0);
    check({tag, "_mdo"},  mem_data_out, 32'd0);
    check({tag, "_mdr"},  mdr_out, 32'd0);
  endtask

  initial begin
    clear = 1'b1; bus_in = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_ready = 0; mem_data_in = '0;
    @(negedge clock);
    // Random-ish prior activity on inputs while reset is held
    bus_in = 32'h0000_01A5; MARin = 1; MDRin = 1; Read = 1; mem_ready = 1;
    step();
    step();
    MARin = 0; MDRin = 0; Read = 0; mem_ready = 0;
    check_idle_zero("reset");
    clear = 1'b0;

    // Write transaction
    bus_in = 32'h0000_0042; MARin = 1; step(); MARin = 0;
    check("mar_load", {23'd0, mem_addr}, 32'h042);
    bus_in = 32'hDEAD_BEEF; MDRin = 1; step(); MDRin = 0;
    check("mdr_load", mdr_out, 32'hDEAD_BEEF);
    Write = 1; step(); Write = 0;
    check("wr_req", {31'd0, mem_wr}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_not_rd", {31'd0, mem_rd}, 32'd0);
    check("wr_addr", {23'd0, mem_addr}, 32'h042);
    check("wr_data", mem_data_out, 32'hDEAD_BEEF);
    mem_ready = 1; mem_data_in = 32'h0BAD_0BAD; step(); mem_ready = 0;
    check("wr_done", {31'd0, done}, 32'd1);
    check("wr_drop", {31'd0, mem_wr}, 32'd0);
    check("wr_mdr_kept", mdr_out, 32'hDEAD_BEEF);
    step();
    check("wr_done_pulse", {31'd0, done}, 32'd0);
    check("wr_idle", {31'd0, busy}, 32'd0);

    // Zero-wait read returning the written word
    bus_in = 32'h0; MDRin = 1; step(); MDRin = 0;
    check("mdr_zeroed", mdr_out, 32'h0);
    Read = 1; mem_ready = 1; mem_data_in = 32'hDEAD_BEEF; step(); Read = 0;
    check("rd_req", {31'd0, mem_rd}, 32'd1);
    step(); mem_ready = 0;
    check("rd_done", {31'd0, done}, 32'd1);
    check("rd_data", mdr_out, 32'hDEAD_BEEF);
    step();
    check("rd_idle", {31'd0, busy}, 32'd0);

    // Read with three wait cycles; bus loads during READ must be ignored
    Read = 1; mem_data_in = 32'h1111_1111; step(); Read = 0;
    check("ws_rd0", {31'd0, mem_rd}, 32'd1);
    bus_in = 32'h0000_1234; MDRin = 1; MARin = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("ws_rd%0d", i), {31'd0, mem_rd}, 32'd1);
      check($sformatf("ws_nodone%0d", i), {31'd0, done}, 32'd0);
    end
    check("ws_mdr_ignored", mdr_out, 32'hDEAD_BEEF);
    check("ws_mar_ignored", {23'd0, mem_addr}, 32'h042);
    mem_ready = 1; mem_data_in = 32'hCAFE_F00D; step();
    mem_ready = 0; MDRin = 0; MARin = 0;
    check("ws_done", {31'd0, done}, 32'd1);
    check("ws_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("ws_data", mdr_out, 32'hCAFE_F00D);
    step();

    // Read and Write together: read wins
    Read = 1; Write = 1; step(); Read = 0; Write = 0;
    check("prio_rd", {31'd0, mem_rd}, 32'd1);
    check("prio_wr", {31'd0, mem_wr}, 32'd0);
    mem_ready = 1; mem_data_in = 32'h5A5A_5A5A; step(); mem_ready = 0;
    check("prio_data", mdr_out, 32'h5A5A_5A5A);
    step();

    // Load and start on the same edge
    bus_in = 32'hFFFF_F1FF; MARin = 1; Write = 1; step(); MARin = 0; Write = 0;
    check("same_addr", {23'd0, mem_addr}, 32'h1FF);
    check("same_wr", {31'd0, mem_wr}, 32'd1);
    mem_ready = 1; step(); mem_ready = 0;
    check("same_done", {31'd0, done}, 32'd1);
    step();

`ifdef MEM_TIMEOUT_EN
    // Read that never completes
    done_seen = 1'b0;
    Read = 1; step(); Read = 0;
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      step();
      done_seen |= done;
    end
    check("to_still_rd", {31'd0, mem_rd}, 32'd1);
    check("to_err_early", {31'd0, error}, 32'd0);
    step();
    done_seen |= done;
    check("to_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("to_err_busy", {31'd0, busy}, 32'd1);
    step();
    done_seen |= done;
    check("to_error", {31'd0, error}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_no_done", {31'd0, done_seen}, 32'd0);
    step();
    check("to_sticky", {31'd0, error}, 32'd1);

    // Next write clears error; ready on the last allowed cycle completes
    Write = 1; step(); Write = 0;
    check("to_err_clr", {31'd0, error}, 32'd0);
    for (int i = 1; i <= TIMEOUT - 1; i++) step();
    check("to_last_wr", {31'd0, mem_wr}, 32'd1);
    mem_ready = 1; step(); mem_ready = 0;
    check("to_late_done", {31'd0, done}, 32'd1);
    check("to_late_err", {31'd0, error}, 32'd0);
    step();
    check("to_late_err2", {31'd0, error}, 32'd0);
`else
    // Without the timeout a request waits indefinitely
    Read = 1; step(); Read = 0;
    for (int i = 1; i <= TIMEOUT + 5; i++) step();
    check("nto_still_rd", {31'd0, mem_rd}, 32'd1);
    check("nto_error", {31'd0, error}, 32'd0);
    mem_ready = 1; mem_data_in = 32'h0F0F_0F0F; step(); mem_ready = 0;
    check("nto_done", {31'd0, done}, 32'd1);
    check("nto_data", mdr_out, 32'h0F0F_0F0F);
    step();
`endif

    // Clear in the middle of a read with ready high
    bus_in = 32'h0000_0077; MDRin = 1; MARin = 1; step(); MDRin = 0; MARin = 0;
    check("mid_preload", mdr_out, 32'h77);
    Read = 1; step(); Read = 0;
    check("mid_rd", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1; mem_data_in = 32'h9999_9999; clear = 1; step();
    clear = 0; mem_ready = 0;
    check_idle_zero("mid_clear");
    step();
    check("mid_no_done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
